// File: rtl/scurve_sweep_ctrl_pkg.sv
// Shared constants for the S-curve threshold sweep controller:
// FSM state codes, stream marker words and DAC-point arithmetic width.
package scurve_sweep_ctrl_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_WLOAD  = 4'd2;
  localparam logic [3:0] S_SETTLE = 4'd3;
  localparam logic [3:0] S_HDR0   = 4'd4;
  localparam logic [3:0] S_HDR1   = 4'd5;
  localparam logic [3:0] S_ACQ    = 4'd6;
  localparam logic [3:0] S_DRAIN  = 4'd7;
  localparam logic [3:0] S_ACK    = 4'd8;
  localparam logic [3:0] S_ACKW   = 4'd9;
  localparam logic [3:0] S_NEXT   = 4'd10;
  localparam logic [3:0] S_TAIL   = 4'd11;
  localparam logic [3:0] S_DONE   = 4'd12;

  localparam logic [15:0] HDR_WORD  = 16'hFF60;
  localparam logic [15:0] TAIL_WORD = 16'hFF69;

  // One guard bit above the DAC code catches step overflow.
  localparam int PT_GUARD = 1;

  function automatic int pt_width(input int dw);
    return dw + PT_GUARD;
  endfunction

endpackage

// File: rtl/scurve_sweep_ctrl_window_timer.sv
// Acquisition window timer: prescaler plus 16-bit tick counter.
// expire_o pulses on the last enabled cycle of ticks*PRESCALE.
module window_timer #(
  parameter int PRESCALE = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] ticks_i,
  output logic        expire_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [15:0]   tick_q;
  logic          wrap;

  assign wrap     = (pre_q == PRE_LAST);
  assign expire_o = en_i & wrap & (tick_q == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= '0;
    end else if (load_i) begin
      pre_q  <= '0;
      tick_q <= (ticks_i == 16'd0) ? 16'd1 : ticks_i;
    end else if (en_i) begin
      pre_q <= wrap ? '0 : pre_q + 1'b1;
      if (wrap) tick_q <= tick_q - 16'd1;
    end
  end

endmodule

// File: rtl/scurve_sweep_ctrl.sv
// S-curve sweep sequencer: DAC load, point header, gated DAQ window,
// end-of-run handshake, and merged output word stream.
module scurve_sweep_ctrl
  import scurve_sweep_ctrl_pkg::*;
#(
  parameter int DAC_WIDTH       = 10,
  parameter int WINDOW_PRESCALE = 1000,
  parameter int SETTLE_CYCLES   = 64
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 SweepStart,
  input  logic [DAC_WIDTH-1:0] SweepStartDac,
  input  logic [DAC_WIDTH-1:0] SweepEndDac,
  input  logic [DAC_WIDTH-1:0] SweepStep,
  input  logic [15:0]          TriggerWindow,
  output logic [DAC_WIDTH-1:0] DacCode,
  output logic                 DacLoad,
  input  logic                 DacLoadDone,
  output logic                 DaqModuleStart,
  input  logic                 DaqAllDone,
  output logic                 DaqDataTransmitDone,
  input  logic [15:0]          DaqData,
  input  logic                 DaqData_en,
  input  logic                 OutFull,
  output logic [15:0]          OutData,
  output logic                 OutData_en,
  output logic                 SweepBusy,
  output logic                 SweepDone,
  output logic                 Overflow,
  output logic [DAC_WIDTH-1:0] CurrentDac
);

  localparam int PTW = pt_width(DAC_WIDTH);
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

  logic [3:0]           state_q, state_d;
  logic                 ss_q;
  logic                 abort_q, abort_d;
  logic                 ovf_q, ovf_d;
  logic [SW-1:0]        set_q, set_d;
  logic [DAC_WIDTH-1:0] cur_q, cur_d;
  logic [DAC_WIDTH-1:0] dac_q, dac_d;
  logic [DAC_WIDTH-1:0] end_q, step_q;
  logic [15:0]          win_q;

  logic           rise, go, abort, stop;
  logic           tmr_load, tmr_en, expire;
  logic [PTW-1:0] nxt;

  assign rise  = SweepStart & ~ss_q;
  assign go    = (state_q == S_IDLE) & rise;
  assign abort = abort_q | ~SweepStart;
  assign nxt   = PTW'(cur_q) + PTW'(step_q);
  assign stop  = (step_q == '0) | (nxt > PTW'(end_q))
               | nxt[PTW-1] | abort;

  assign tmr_load = (state_q == S_HDR1) & ~OutFull;
  assign tmr_en   = (state_q == S_ACQ);

  window_timer #(
    .PRESCALE (WINDOW_PRESCALE)
  ) u_timer (
    .clk      (Clk),
    .rst      (reset),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .ticks_i  (win_q),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    ovf_d      = ovf_q;
    set_d      = set_q;
    cur_d      = cur_q;
    OutData    = DaqData;
    OutData_en = DaqData_en & ~OutFull;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          abort_d = 1'b0;
          ovf_d   = 1'b0;
          if (SweepStartDac > SweepEndDac) begin
            state_d = S_TAIL;
          end else begin
            cur_d   = SweepStartDac;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: state_d = S_WLOAD;
      S_WLOAD: begin
        if (DacLoadDone) begin
          set_d   = '0;
          state_d = abort ? S_TAIL : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) state_d = S_TAIL;
        else if (set_q == SET_LAST) state_d = S_HDR0;
        else set_d = set_q + 1'b1;
      end
      S_HDR0: begin
        OutData    = HDR_WORD;
        OutData_en = ~OutFull;
        if (!OutFull) state_d = S_HDR1;
      end
      S_HDR1: begin
        OutData    = 16'(cur_q);
        OutData_en = ~OutFull;
        if (!OutFull) state_d = S_ACQ;
      end
      S_ACQ: if (abort || expire) state_d = S_DRAIN;
      S_DRAIN: if (DaqAllDone) state_d = S_ACK;
      S_ACK: state_d = S_ACKW;
      S_ACKW: if (!DaqAllDone) state_d = S_NEXT;
      S_NEXT: begin
        if (stop) begin
          state_d = S_TAIL;
        end else begin
          cur_d   = nxt[DAC_WIDTH-1:0];
          state_d = S_LOAD;
        end
      end
      S_TAIL: begin
        OutData    = TAIL_WORD;
        OutData_en = ~OutFull;
        if (!OutFull) state_d = S_DONE;
      end
      S_DONE: if (!SweepStart) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort is remembered so NEXT still routes to TAIL after a re-raise.
    if (state_q != S_IDLE && state_q != S_DONE && !SweepStart)
      abort_d = 1'b1;
    if (DaqData_en && OutFull) ovf_d = 1'b1;
    dac_d = (state_d == S_LOAD) ? cur_d : dac_q;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ss_q    <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      set_q   <= '0;
      cur_q   <= '0;
      dac_q   <= '0;
      end_q   <= '0;
      step_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      ss_q    <= SweepStart;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
      set_q   <= set_d;
      cur_q   <= cur_d;
      dac_q   <= dac_d;
      if (go) begin
        end_q  <= SweepEndDac;
        step_q <= SweepStep;
        win_q  <= TriggerWindow;
      end
    end
  end

  assign DacCode             = dac_q;
  assign DacLoad             = (state_q == S_LOAD);
  assign DaqModuleStart      = (state_q == S_ACQ);
  assign DaqDataTransmitDone = (state_q == S_ACK);
  assign SweepBusy           = (state_q != S_IDLE) & (state_q != S_DONE);
  assign SweepDone           = (state_q == S_DONE);
  assign Overflow            = ovf_q;
  assign CurrentDac          = cur_q;

endmodule

// File: doc/scurve_sweep_ctrl.md
Name: scurve_sweep_ctrl

Overview:
Sequences an S-curve threshold sweep around the slave DAQ engine. For each DAC point it loads the threshold through the slow-control loader and emits a two-word point header. It then runs one gated DAQ acquisition window and waits for the DAQ's end-of-run tail. It also owns the output word stream, merging its own header and tail words with the DAQ pass-through data towards the USB FIFO.

Parameters:
DAC_WIDTH, 10, threshold DAC code width
WINDOW_PRESCALE, 1000, Clk cycles per TriggerWindow tick
SETTLE_CYCLES, 64, Clk cycles between DacLoadDone and header emission

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SweepStart  in  1  level from USB; rising edge starts a sweep, low aborts
SweepStartDac  in  DAC_WIDTH  first DAC code
SweepEndDac  in  DAC_WIDTH  last allowed DAC code (inclusive)
SweepStep  in  DAC_WIDTH  code increment per point
TriggerWindow  in  16  acquisition window per point, in prescaler ticks
DacCode  out  DAC_WIDTH  threshold code for the slow-control loader
DacLoad  out  1  one-cycle load request
DacLoadDone  in  1  one-cycle pulse from the loader when the code is applied
DaqModuleStart  out  1  ModuleStart to the slave DAQ
DaqAllDone  in  1  AllDone from the slave DAQ (level)
DaqDataTransmitDone  out  1  acknowledge to the slave DAQ
DaqData  in  16  slave DAQ data word
DaqData_en  in  1  slave DAQ data strobe
OutFull  in  1  downstream FIFO full
OutData  out  16  merged data word
OutData_en  out  1  merged data strobe
SweepBusy  out  1  high from start until DONE
SweepDone  out  1  high in DONE
Overflow  out  1  sticky: DaqData_en seen while OutFull
CurrentDac  out  DAC_WIDTH  code of the point in progress

Behaviour:
- Reset values: all outputs 0. CurrentDac=0 and DacCode=0. State=IDLE.
- State path: IDLE -> LOAD -> WAIT_LOAD -> SETTLE -> HDR0 -> HDR1 -> ACQ -> DRAIN -> ACK -> NEXT -> (LOAD | TAIL) -> DONE.
- IDLE:
  - On a SweepStart rising edge (registered edge detect), latch Start/End/Step/Window and set SweepBusy.
  - If Start>End, go directly to TAIL (zero points).
  - Otherwise set CurrentDac=Start and go to LOAD.
- LOAD: DacCode=CurrentDac; DacLoad high for exactly 1 cycle; go to WAIT_LOAD.
- WAIT_LOAD: wait for DacLoadDone (no timeout), then go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles.
- HDR0: output word 16'hFF60.
- HDR1: output word {(16-DAC_WIDTH)'b0, CurrentDac}.
- Header and tail word emission rule: OutData_en high for 1 cycle only when OutFull=0; otherwise stall in the state.
- ACQ:
  - DaqModuleStart=1.
  - Tick counter counts WINDOW_PRESCALE cycles per tick. TriggerWindow=0 is treated as 1.
  - After Window*WINDOW_PRESCALE cycles, DaqModuleStart=0 and go to DRAIN.
- DRAIN: wait for DaqAllDone=1.
- ACK: DaqDataTransmitDone=1 for 1 cycle, then wait for DaqAllDone=0 before entering NEXT.
- NEXT:
  - next = CurrentDac + Step, computed at DAC_WIDTH+1 bits.
  - If Step==0, or next>End, or next overflows DAC_WIDTH, or an abort is pending, go to TAIL.
  - Otherwise CurrentDac=next and go to LOAD.
- TAIL: emit 16'hFF69 (same stall rule), then go to DONE.
- DONE: SweepDone=1; SweepBusy=0; return to IDLE when SweepStart=0.
- Pass-through: outside HDR0/HDR1/TAIL, OutData=DaqData and OutData_en=DaqData_en&~OutFull, combinationally.
- Overflow: set when DaqData_en&OutFull; cleared only by reset or by a new sweep start.
- Abort (SweepStart=0 while busy):
  - LOAD/WAIT_LOAD/SETTLE: complete the load handshake, then go to TAIL (no header emitted).
  - HDR0/HDR1: finish the headers; ACQ then ends at the next cycle.
  - ACQ: drop DaqModuleStart immediately and go to DRAIN; the point still completes through ACK.
  - DRAIN/ACK: continue normally; NEXT routes to TAIL.
- DacLoadDone or DaqAllDone outside the states that wait for them: ignored.
- Reset mid-sweep: all outputs return to reset values within the reset assertion. No tail word is emitted.

Decomposition:
- Shared package: state encoding; header/tail constants 16'hFF60 and 16'hFF69; the DAC-point arithmetic width.
- One sub-module, window_timer: prescaler plus 16-bit tick counter, with load, enable and expire pulse. All else stays in the FSM.

Test Plan:
1. Start=100, End=110, Step=5, Window=1, prescale 8 -> 3 points (100, 105, 110). Each point: DacLoad, then FF60 and 0x0064/0x0069/0x006E, then DaqModuleStart high 8 cycles. Stream ends with FF69; SweepDone=1.
2. Start=1020, End=1023, Step=8 -> single point 1020, no wrap, then tail.
3. Start=50, End=40 -> no DacLoad, no DaqModuleStart, output only FF69, SweepDone=1.
4. SweepStart dropped 3 cycles into ACQ of point 2 -> DaqModuleStart falls within 1 cycle; ACK still issued; FF69 follows; no point 3.
5. OutFull held high 10 cycles during HDR0 -> no strobe while full; FF60 emitted exactly once after release. DaqData_en during OutFull in ACQ sets Overflow sticky.
6. Reset asserted during DRAIN -> all outputs 0 and IDLE. A subsequent SweepStart edge starts a clean sweep with Overflow cleared.
